lcd_rx: RTL

LCD_RX -- requirements
Module: lcd_rx

---
 rtl/lcd_pkg.sv | 62 ++++++
 rtl/lcd_sync_edge.sv | 45 ++++
 rtl/lcd_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by lcd_rx: LCD_RX_ERR_EN.
package lcd_pkg;

  // Controller states: IDLE accepts strobes, EXEC/CLEAR are busy.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int         DDRAM_DEPTH = 32;
  localparam int         ADDR_W      = 5;
  localparam logic [7:0] SPACE_CODE  = 8'h20;

  // Instruction masks; the highest set bit of d selects the command.
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_CLEAR     = 3'd1,
    OP_HOME      = 3'd2,
    OP_ENTRY     = 3'd3,
    OP_DISP      = 3'd4,
    OP_SHIFT     = 3'd5,
    OP_FUNC      = 3'd6,
    OP_SET_DDRAM = 3'd7
  } op_e;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] idx;
  } ddram_map_t;

  // Priority decode on the most significant set bit.
  function automatic op_e decode_cmd(input logic [7:0] v);
    if (|(v & CMD_SET_DDRAM)) return OP_SET_DDRAM;
    if (|(v & CMD_FUNC_SET))  return OP_FUNC;
    if (|(v & CMD_SHIFT))     return OP_SHIFT;
    if (|(v & CMD_DISP_CTRL)) return OP_DISP;
    if (|(v & CMD_ENTRY))     return OP_ENTRY;
    if (|(v & CMD_HOME))      return OP_HOME;
    if (|(v & CMD_CLEAR))     return OP_CLEAR;
    return OP_NOP;
  endfunction

  // LCD address 0x00-0x0F -> index 0-15, 0x40-0x4F -> index 16-31.
  function automatic ddram_map_t map_ddram(input logic [6:0] a);
    ddram_map_t m;
    m.ok  = (a[5:4] == 2'b00);
    m.idx = {a[6], a[3:0]};
    return m;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Synchronizes the LCD bus and detects the falling edge of e (the strobe).
// Latency: strobe is valid 2 clocks after e falls; rs/d are from the same samples.
// Backpressure: none; strobes are single-cycle and must be consumed or dropped.
module lcd_sync_edge (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] d,
  output logic       strobe,
  output logic       strobe_rs,
  output logic [7:0] strobe_d
);

  // Bit layout: [9]=rs, [8]=e, [7:0]=d.
  logic [9:0] meta_q;
  logic [9:0] sync_q;
  logic [1:0] fill_q;
  logic       arm_q;
  logic       e_prev_q;

  // Two-flop synchronizer plus edge history. The detector only arms once the
  // pipeline holds post-reset samples and e has been seen low, so an e pulse
  // that straddles reset release never produces a strobe.
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      fill_q   <= '0;
      arm_q    <= 1'b0;
      e_prev_q <= 1'b0;
    end else begin
      meta_q   <= {rs, e, d};
      sync_q   <= meta_q;
      fill_q   <= {fill_q[0], 1'b1};
      e_prev_q <= sync_q[8];
      if (fill_q[1] && !sync_q[8]) arm_q <= 1'b1;
    end
  end

  assign strobe    = arm_q && e_prev_q && !sync_q[8];
  assign strobe_rs = sync_q[9];
  assign strobe_d  = sync_q[7:0];

endmodule

// File: rtl/lcd_rx.sv
// LCD bus receiver: decodes writes into a 32x8 DDRAM, tracks cursor and busy time.
// Latency: e falling edge to action 3 clocks; rd_data 1 clock after rd_addr.
// Backpressure: strobes while busy are dropped (protocol_error if LCD_RX_ERR_EN).
module lcd_rx #(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] d,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic       busy,
  output logic       protocol_error,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);
  import lcd_pkg::*;

  localparam int CNT_MAX = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic              stb;
  logic              stb_rs;
  logic [7:0]        stb_d;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] ac_q;
  logic              inc_q;
  logic              display_on_q;
  logic              busy_q;
  logic              char_valid_q;
  logic [7:0]        char_data_q;
  logic [ADDR_W-1:0] char_addr_q;
  logic              protocol_error_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        ram_q [DDRAM_DEPTH];

  op_e               op_d;
  ddram_map_t        map_d;
  logic [ADDR_W-1:0] ac_step_d;
  logic              err_d;
  logic              err_out;
  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_waddr_d;
  logic [7:0]        ram_wdata_d;

  lcd_sync_edge u_sync (
    .clock          (clock),
    .internal_reset (internal_reset),
    .rs             (rs),
    .e              (e),
    .d              (d),
    .strobe         (stb),
    .strobe_rs      (stb_rs),
    .strobe_d       (stb_d)
  );

  // Command decode, cursor step and bus-violation detection.
  always_comb begin
    op_d      = decode_cmd(stb_d);
    map_d     = map_ddram(stb_d[6:0]);
    ac_step_d = inc_q ? (ac_q + 5'd1) : (ac_q - 5'd1);
    err_d     = stb && ((state_q != ST_IDLE) ||
                        (!stb_rs && (op_d == OP_SET_DDRAM) && !map_d.ok));
  end

`ifdef LCD_RX_ERR_EN
  assign err_out = err_d;
`else
  // Offending strobes are still dropped by the FSM; only the report is removed.
  assign err_out = 1'b0;
  logic unused_err;
  assign unused_err = err_d;
`endif

  // display_on is architectural state with no output in this block.
  logic unused_display_on;
  assign unused_display_on = display_on_q;

  // RAM write port: data writes in IDLE, space fill one index per cycle in CLEAR.
  always_comb begin
    ram_we_d    = 1'b0;
    ram_waddr_d = ac_q;
    ram_wdata_d = stb_d;
    if (state_q == ST_CLEAR) begin
      ram_we_d    = 1'b1;
      ram_waddr_d = cnt_q[ADDR_W-1:0];
      ram_wdata_d = SPACE_CODE;
    end else if ((state_q == ST_IDLE) && stb && stb_rs) begin
      ram_we_d = 1'b1;
    end
  end

  // DDRAM storage; deliberately not reset so contents survive internal_reset.
  always_ff @(posedge clock) begin
    if (ram_we_d) ram_q[ram_waddr_d] <= ram_wdata_d;
  end

  // Registered readback, independent of the write activity.
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) rd_data_q <= '0;
    else                rd_data_q <= ram_q[rd_addr];
  end

  // Controller FSM with registered outputs and busy timer.
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      ac_q             <= '0;
      inc_q            <= 1'b1;
      display_on_q     <= 1'b0;
      busy_q           <= 1'b0;
      char_valid_q     <= 1'b0;
      char_data_q      <= '0;
      char_addr_q      <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      char_valid_q     <= 1'b0;
      protocol_error_q <= err_out;
      case (state_q)
        ST_IDLE: begin
          if (stb) begin
            state_q <= ST_EXEC;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(CMD_CYCLES - 1);
            if (stb_rs) begin
              char_valid_q <= 1'b1;
              char_data_q  <= stb_d;
              char_addr_q  <= ac_q;
              ac_q         <= ac_step_d;
            end else begin
              case (op_d)
                OP_SET_DDRAM: if (map_d.ok) ac_q <= map_d.idx;
                OP_DISP:      display_on_q <= stb_d[2];
                OP_ENTRY:     inc_q <= stb_d[1];
                OP_HOME:      ac_q <= '0;
                OP_CLEAR: begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
                  ac_q    <= '0;
                  inc_q   <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          // After the 32-cycle fill, the rest of the clear time is spent in EXEC.
          if (cnt_q == CNT_W'(DDRAM_DEPTH - 1)) begin
            if (CLEAR_CYCLES > DDRAM_DEPTH) begin
              state_q <= ST_EXEC;
              cnt_q   <= CNT_W'(CLEAR_CYCLES - DDRAM_DEPTH - 1);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign char_valid     = char_valid_q;
  assign char_data      = char_data_q;
  assign char_addr      = char_addr_q;
  assign busy           = busy_q;
  assign protocol_error = protocol_error_q;
  assign rd_data        = rd_data_q;

endmodule
